// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the RV32I subset encoder/loader: op selects, opcodes,
// funct fields, loader state encoding and the NOP word used for padding.
package instr_encoder_loader_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 12;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_LW   = 3'd0;
  localparam logic [OP_W-1:0] OP_SW   = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_ADDI = 3'd4;
  localparam logic [OP_W-1:0] OP_SRL  = 3'd5;
  localparam logic [OP_W-1:0] OP_BEQ  = 3'd6;
  localparam logic [OP_W-1:0] OP_ILL  = 3'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ENC  = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_PAD  = 3'd4
  } state_t;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational field-to-word packer for the supported RV32I subset; illegal
// ops yield an all-zero word.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic [IMM_W-1:0]  imm,
  output logic [WORD_W-1:0] word_c
);

  always_comb begin
    word_c = '0;
    case (op)
      OP_LW:   word_c = {imm, rs1, F3_LW, rd, OPC_LOAD};
      OP_ADDI: word_c = {imm, rs1, F3_ADD, rd, OPC_OP_IMM};
      OP_SW:   word_c = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
      OP_SUB:  word_c = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_OP};
      OP_XOR:  word_c = {F7_BASE, rs2, rs1, F3_XOR, rd, OPC_OP};
      OP_SRL:  word_c = {F7_BASE, rs2, rs1, F3_SRL, rd, OPC_OP};
      // imm holds branch offset bits [12:1]
      OP_BEQ:  word_c = {imm[11], imm[9:4], rs2, rs1, F3_BEQ, imm[3:0], imm[10], OPC_BRANCH};
      default: word_c = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes decoded field tuples into RV32I words and writes them sequentially
// into instruction memory. Define LOADER_NOP_PAD_EN to fill the rest with NOPs.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_last,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [CNT_W-1:0]  count,
  output logic              done,
  output logic              full,
  output logic              err
);

  state_t             state;
  logic [OP_W-1:0]    op_q;
  logic [REG_W-1:0]   rd_q;
  logic [REG_W-1:0]   rs1_q;
  logic [REG_W-1:0]   rs2_q;
  logic [IMM_W-1:0]   imm_q;
  logic               last_q;
  logic [WORD_W-1:0]  word_c;
  logic [CNT_W-1:0]   count_inc;

  assign count_inc = count + CNT_W'(1);

  instr_pack u_pack (
    .op     (op_q),
    .rd     (rd_q),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .imm    (imm_q),
    .word_c (word_c)
  );

  // Loader FSM; mem_we is a one-cycle strobe unless padding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      done      <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= in_op;
            rd_q     <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            imm_q    <= in_imm;
            last_q   <= in_last;
            in_ready <= 1'b0;
            state    <= ST_ENC;
          end
        end
        ST_ENC: begin
          mem_wdata <= word_c;
          if (op_q == OP_ILL) begin
            err      <= 1'b1;
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            mem_we <= 1'b1;
            state  <= ST_WR;
          end
        end
        ST_WR: begin
          mem_addr <= mem_addr + ADDR_W'(4);
          count    <= count_inc;
          if (count_inc == CNT_W'(DEPTH)) begin
            full  <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (last_q) begin
`ifdef LOADER_NOP_PAD_EN
            mem_we    <= 1'b1;
            mem_wdata <= NOP_WORD;
            state     <= ST_PAD;
`else
            done  <= 1'b1;
            state <= ST_DONE;
`endif
          end else begin
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
`ifdef LOADER_NOP_PAD_EN
        ST_PAD: begin
          mem_addr <= mem_addr + ADDR_W'(4);
          count    <= count_inc;
          if (count_inc == CNT_W'(DEPTH)) begin
            full  <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            mem_we <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          // err is sticky across restart
          if (restart) begin
            mem_addr <= '0;
            count    <= '0;
            done     <= 1'b0;
            full     <= 1'b0;
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
